dpi_burst_streamer: RTL and testbench

Parametrised burst-read engine for the simulation VM. It accepts a read request of arbitrary length, splits it into DPI-C bursts of at most `MAX_BURST` 64-bit words, and buffers each burst. It then streams the words out one per cycle over a valid/ready interface with backpressure. It sits between VM control logic (request side) and consumers such as the NTT/ALU load paths (stream side). Host memory is reached only through `dpi_read_burst`.

---
 rtl/dpi_burst_streamer.sv | 170 +++++++++++++++++
 tb/tb_dpi_burst_streamer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_burst_streamer.sv
// dpi_burst_streamer: splits a word-granular read request into bursts of at
// most MAX_BURST 64-bit words, fetches each burst from host memory with one
// dpi_read_burst call, and streams the buffered words over valid/ready.
//
// Host-memory binding. The VM links dpi_read_burst to its C++ memory. This
// self-contained build binds the same signature to a SystemVerilog body, so
// the bundle elaborates without a C object. Host word at byte address a holds
// 0x1000 + a/8. Every call is appended to a log so callers can see how many
// bursts were issued and with which arguments.
package dpi_burst_host_pkg;

    longint call_addr_log[$];
    int     call_len_log[$];

    function automatic void dpi_read_burst(input longint addr, input int len,
                                           output bit [63:0] data[]);
        data = new[len];
        for (int i = 0; i < len; i++) begin
            data[i] = 64'h1000 + ((64'(addr) + 64'(i) * 64'd8) >> 3);
        end
        call_addr_log.push_back(addr);
        call_len_log.push_back(len);
    endfunction

endpackage

// state  | meaning
// IDLE   | waiting for a request; req_ready high
// FETCH  | one cycle: read the next burst into the buffer
// STREAM | present buffered words one per handshake
module dpi_burst_streamer #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic [LEN_W-1:0] out_beat,
    output logic             busy,
    output logic             err
);
    import dpi_burst_host_pkg::*;

    localparam int IW = $clog2(MAX_BURST);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       cur_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [IW-1:0]     rd_idx_q;
    logic [CW-1:0]     chunk_len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              err_q;
    bit   [63:0]       buf_q [0:MAX_BURST-1];

    logic              req_bad;
    logic              chunk_done;
    logic [CW-1:0]     chunk_w;

    assign req_bad    = (req_len == '0) || (req_addr[2:0] != 3'b000);
    assign chunk_done = ({1'b0, rd_idx_q} == (chunk_len_q - CW'(1)));
    assign out_beat   = beat_q;
    assign err        = err_q;

    // Size of the next burst: whatever is left, capped at the buffer depth.
    always_comb begin
        chunk_w = remaining_q[CW-1:0];
        if (remaining_q > LEN_W'(MAX_BURST)) begin
            chunk_w = CW'(MAX_BURST);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stream-side outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !req_bad) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy    = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = buf_q[rd_idx_q];
                out_last  = (remaining_q == '0) && chunk_done;
                if (out_ready && chunk_done) begin
                    state_d = (remaining_q != '0) ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, burst fetch (the only place host memory is read) and beat counters.
    always_ff @(posedge clk) begin : datapath
        bit [63:0] words [];
        if (!rst_n) begin
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_idx_q    <= '0;
            chunk_len_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state_q == IDLE) && req_valid && req_bad;
            case (state_q)
                IDLE: begin
                    if (req_valid && !req_bad) begin
                        cur_addr_q  <= req_addr;
                        remaining_q <= req_len;
                        beat_q      <= '0;
                    end
                end
                FETCH: begin
                    dpi_read_burst(longint'(cur_addr_q), int'(chunk_w), words);
                    for (int i = 0; i < MAX_BURST; i++) begin
                        if (i < int'(chunk_w)) begin
                            buf_q[i] <= words[i];
                        end
                    end
                    remaining_q <= remaining_q - LEN_W'(chunk_w);
                    cur_addr_q  <= cur_addr_q + (64'(chunk_w) << 3);
                    rd_idx_q    <= '0;
                    chunk_len_q <= chunk_w;
                end
                STREAM: begin
                    if (out_ready) begin
                        rd_idx_q <= rd_idx_q + IW'(1);
                        beat_q   <= beat_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_burst_streamer.sv
// Bench for dpi_burst_streamer: table of directed requests, randomized
// requests, and a hand-written reset-during-stream sequence. Expected beats,
// burst calls and bubble counts come from a request-level model.
module tb_dpi_burst_streamer;

    localparam int M = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic [15:0] out_beat;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dpi_burst_streamer #(.MAX_BURST(M), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          mode;       // 0: ready held 1, 1: fixed pattern, 2: random
        bit          exp_err;
        int          exp_calls;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Model: host word at byte address a is 0x1000 + a/8 (64-bit address wrap).
    function automatic logic [63:0] model_word(input logic [63:0] base, input int k);
        logic [63:0] a;
        a = base + 64'(k) * 64'd8;
        return 64'h1000 + (a >> 3);
    endfunction

    function automatic int model_calls(input int len);
        return (len + M - 1) / M;
    endfunction

    // Starts and ends right after a falling edge.
    task automatic run_req(input logic [63:0] addr, input int len, input int mode,
                           input bit exp_err, input int exp_calls);
        int base;
        int k;
        int cyc;
        int first_valid;
        int bubbles;
        int pat_idx;
        int budget;
        bit stalled;
        logic [63:0] prev_data;
        logic [15:0] prev_beat;
        logic        prev_last;
        bit pat [8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        base = dpi_burst_host_pkg::call_len_log.size();
        check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = 16'(len);
        out_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 16'($urandom);
        if (exp_err) begin
            check("err_pulse", {63'd0, err}, 64'd1);
            check("err_req_ready", {63'd0, req_ready}, 64'd1);
            check("err_out_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check("err_one_cycle", {63'd0, err}, 64'd0);
            check("err_no_busy", {63'd0, busy}, 64'd0);
            check("err_no_calls", 64'(dpi_burst_host_pkg::call_len_log.size() - base), 64'd0);
            return;
        end
        check("no_err_on_good_req", {63'd0, err}, 64'd0);
        k = 0; cyc = 0; first_valid = -1; bubbles = 0; pat_idx = 0; stalled = 0;
        prev_data = '0; prev_beat = '0; prev_last = 1'b0;
        budget = 6 * len + 40;
        while (k < len && cyc < budget) begin
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_beat_stable", 64'(out_beat), 64'(prev_beat));
                    check("stall_last_stable", {63'd0, out_last}, {63'd0, prev_last});
                end
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = (pat_idx < 8) ? pat[pat_idx] : 1'b1;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                pat_idx++;
            end else begin
                if (first_valid >= 0) bubbles++;
                out_ready = 1'($urandom_range(0, 1));
            end
            if (out_valid && out_ready) begin
                check("beat_data", out_data, model_word(addr, k));
                check("beat_index", 64'(out_beat), 64'(k));
                check("beat_last", {63'd0, out_last}, {63'd0, (k == len - 1)});
                k++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
            end
            prev_data = out_data;
            prev_beat = out_beat;
            prev_last = out_last;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (k < len) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d beats, want %0d", k, len);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        check("done_req_ready", {63'd0, req_ready}, 64'd1);
        check("done_out_valid", {63'd0, out_valid}, 64'd0);
        check("done_busy", {63'd0, busy}, 64'd0);
        check("first_valid_latency", 64'(first_valid), 64'd1);
        check("bubble_count", 64'(bubbles), 64'(model_calls(len) - 1));
        check("call_count", 64'(dpi_burst_host_pkg::call_len_log.size() - base), 64'(exp_calls));
        if (dpi_burst_host_pkg::call_len_log.size() - base == exp_calls) begin
            for (int c = 0; c < exp_calls; c++) begin
                int rem;
                rem = len - c * M;
                check("call_addr", 64'(dpi_burst_host_pkg::call_addr_log[base + c]),
                      addr + 64'(c) * 64'(M) * 64'd8);
                check("call_len", 64'(dpi_burst_host_pkg::call_len_log[base + c]),
                      64'((rem > M) ? M : rem));
            end
        end
    endtask

    initial begin
        int base;
        int cyc;
        vecs[0] = '{64'h0,                  10, 0, 1'b0, 1};
        vecs[1] = '{64'h80,                 40, 0, 1'b0, 3};
        vecs[2] = '{64'h200,                 5, 1, 1'b0, 1};
        vecs[3] = '{64'h0,                   0, 0, 1'b1, 0};
        vecs[4] = '{64'h4,                   3, 0, 1'b1, 0};
        vecs[5] = '{64'h300,                16, 0, 1'b0, 1};
        vecs[6] = '{64'h8,                  17, 2, 1'b0, 2};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF8, 20, 0, 1'b0, 2};
        vecs[8] = '{64'h1000,               32, 2, 1'b0, 2};
        vecs[9] = '{64'h20,                  1, 1, 1'b0, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_beat", 64'(out_beat), 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].exp_err, vecs[i].exp_calls);
            @(negedge clk);
        end

        for (int i = 0; i < 25; i++) begin
            logic [63:0] a;
            int l;
            bit bad;
            a = {$urandom, $urandom} & ~64'h7;
            l = $urandom_range(1, 50);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) l = 0;
                else a[2:0] = 3'($urandom_range(1, 7));
            end
            bad = (l == 0) || (a[2:0] != 3'b0);
            run_req(a, l, 2, bad, bad ? 0 : model_calls(l));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of the second burst of a 40-word request.
        base = dpi_burst_host_pkg::call_len_log.size();
        req_valid = 1'b1;
        req_addr  = 64'h400;
        req_len   = 16'd40;
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            if (out_valid && out_beat == 16'd20) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("midrst_reached_beat20", {63'd0, (cyc < 200)}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_beat", 64'(out_beat), 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_out_data", out_data, 64'd0);
        repeat (3) @(negedge clk);
        check("midrst_out_valid_quiet", {63'd0, out_valid}, 64'd0);
        check("midrst_call_count", 64'(dpi_burst_host_pkg::call_len_log.size() - base), 64'd2);
        out_ready = 1'b0;
        run_req(64'h40, 3, 0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
